round_engine: RTL and testbench

- Iterative, parametrised round engine for the AES variant with dynamic shift rows and a bit-permuted mix column.
- Takes one 128-bit block per transaction and performs initial key whitening.
- Then runs a run-time selectable number of rounds (subBytes -> nov_shiftrow -> bit_perm -> addroundkey) through a single shared datapath.
- Returns the result over a valid/ready handshake. Round keys are fetched from an external key store by index.

---
 rtl/round_engine.sv | 236 +++++++++++++++++++++++
 tb/tb_round_engine.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/round_engine.sv
// Iterative AES-variant round engine: key whitening, then nrl rounds of
// subBytes -> nov_shiftrow -> bit_perm -> addroundkey on one datapath.
module round_engine #(
  parameter int NR        = 10,
  parameter int SBOX_LAT  = 1,
  parameter int LAST_PERM = 0,
  parameter int KW        = $clog2(NR + 1)
) (
  input  logic          clk,
  input  logic          rst_an,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  data_in,
  input  logic [KW-1:0] nr_sel,
  input  logic          select,
  input  logic          flush,
  output logic [KW-1:0] key_idx,
  input  logic [127:0]  round_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  data_out,
  output logic          busy
);

  localparam int SW = $clog2(SBOX_LAT + 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(SBOX_LAT - 1);
  localparam logic [KW-1:0] NR_K = KW'(NR);

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    ADD,
    DONE
  } state_t;

  state_t        st_q, st_d;
  logic [127:0]  state_q, state_d;
  logic [KW-1:0] rnd_q, rnd_d;
  logic [KW-1:0] nrl_q, nrl_d;
  logic          sel_q, sel_d;
  logic [SW-1:0] sub_q, sub_d;
  logic [127:0]  pipe_d;
  logic [127:0]  pipe_q [SBOX_LAT];
  logic [127:0]  shifted;
  logic [127:0]  permuted;
  logic [127:0]  add_out;

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in,
                                      input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in;
    b = b_in;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  // x^254 is the field inverse, with 0 mapping to 0 for free
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r, t;
    r = 8'h01;
    t = x;
    for (int i = 1; i < 8; i++) begin
      t = gmul(t, t);
      r = gmul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] x,
                                           input logic inv);
    logic [7:0] y;
    if (inv) begin
      y = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
      y = ginv(y);
    end else begin
      y = ginv(x);
      y = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3)
            ^ rotl(y, 4) ^ 8'h63;
    end
    return y;
  endfunction

  // byte k = 4*col + row sits at bits [8*(15-k) +: 8]
  function automatic logic [127:0] nov_shiftrow(input logic [127:0] s,
                                                input logic [KW-1:0] rnd);
    logic [127:0] o;
    logic [1:0]   c2, r2, sh;
    logic [3:0]   dk, sk;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        c2 = 2'(c);
        r2 = 2'(r);
        sh = r2 + 2'(rnd);
        dk = {c2, r2};
        sk = {c2 + sh, r2};
        o[{~dk, 3'b000} +: 8] = s[{~sk, 3'b000} +: 8];
      end
    end
    return o;
  endfunction

  // 37 is odd, so i*37 mod 128 is a bijection on bit positions
  function automatic logic [127:0] bit_perm(input logic [127:0] s);
    logic [127:0] o;
    logic [6:0]   d, src;
    o = '0;
    for (int i = 0; i < 128; i++) begin
      d = 7'(i);
      src = d * 7'd37;
      o[d] = s[src];
    end
    return o;
  endfunction

  always_comb begin
    logic [3:0] kk;
    pipe_d = '0;
    for (int k = 0; k < 16; k++) begin
      kk = 4'(k);
      pipe_d[{~kk, 3'b000} +: 8] =
        sbox_byte(state_q[{~kk, 3'b000} +: 8], sel_q);
    end
  end

  for (genvar g = 0; g < SBOX_LAT; g++) begin : g_sbox_pipe
    if (g == 0) begin : g_first
      always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) pipe_q[0] <= '0;
        else         pipe_q[0] <= pipe_d;
      end
    end else begin : g_rest
      always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) pipe_q[g] <= '0;
        else         pipe_q[g] <= pipe_q[g-1];
      end
    end
  end

  always_comb begin
    shifted = nov_shiftrow(pipe_q[SBOX_LAT-1], rnd_q);
    if ((rnd_q == nrl_q) && (LAST_PERM == 0)) permuted = shifted;
    else                                       permuted = bit_perm(shifted);
    add_out = permuted ^ round_key;
  end

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    nrl_d   = nrl_q;
    sel_d   = sel_q;
    sub_d   = sub_q;
    unique case (st_q)
      IDLE: begin
        if (in_valid) begin
          state_d = data_in ^ round_key;
          nrl_d   = ((nr_sel == '0) || (nr_sel > NR_K)) ? NR_K : nr_sel;
          sel_d   = select;
          rnd_d   = KW'(1);
          sub_d   = '0;
          st_d    = SUB;
        end
      end
      SUB: begin
        if (sub_q == SUB_LAST) begin
          sub_d = '0;
          st_d  = ADD;
        end else begin
          sub_d = sub_q + SW'(1);
        end
      end
      ADD: begin
        state_d = add_out;
        if (rnd_q == nrl_q) begin
          st_d = DONE;
        end else begin
          rnd_d = rnd_q + KW'(1);
          st_d  = SUB;
        end
      end
      DONE: begin
        if (out_ready) st_d = IDLE;
      end
    endcase
    // abort wins over accept and over the output handshake
    if (flush) begin
      st_d    = IDLE;
      state_d = '0;
      rnd_d   = '0;
      sub_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_an) begin
    if (!rst_an) begin
      st_q    <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
      nrl_q   <= '0;
      sel_q   <= 1'b0;
      sub_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
      nrl_q   <= nrl_d;
      sel_q   <= sel_d;
      sub_q   <= sub_d;
    end
  end

  always_comb begin
    key_idx = '0;
    unique case (1'b1)
      st_q == IDLE:                  key_idx = '0;
      (st_q == SUB) || (st_q == ADD): key_idx = rnd_q;
      st_q == DONE:                  key_idx = nrl_q;
    endcase
  end

  assign in_ready  = (st_q == IDLE);
  assign out_valid = (st_q == DONE);
  assign busy      = (st_q != IDLE);
  assign data_out  = state_q;

endmodule

// File: tb/tb_round_engine.sv
// Directed + random bench for round_engine, two parameter sets,
// checked against a byte-array reference model of the cipher rounds.
module tb_round_engine;

  logic         clk = 1'b0;
  logic         rst_an = 1'b0;
  logic         in_valid = 1'b0;
  logic         select = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] din = '0;
  logic [3:0]   nr_sel = '0;
  int           cur = 0;

  logic         ir_a, ov_a, busy_a, ir_b, ov_b, busy_b;
  logic [3:0]   kidx_a, kidx_b;
  logic [127:0] dout_a, dout_b, rk_a, rk_b;
  logic         ir, ov, busy;
  logic [3:0]   kidx;
  logic [127:0] dout;

  logic [127:0] ktab [16];
  logic [7:0]   fwd [256];
  logic [7:0]   inv [256];

  int vectors = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign rk_a = ktab[kidx_a];
  assign rk_b = ktab[kidx_b];
  assign ir   = (cur == 1) ? ir_b : ir_a;
  assign ov   = (cur == 1) ? ov_b : ov_a;
  assign busy = (cur == 1) ? busy_b : busy_a;
  assign kidx = (cur == 1) ? kidx_b : kidx_a;
  assign dout = (cur == 1) ? dout_b : dout_a;

  round_engine u_a (
    .clk(clk), .rst_an(rst_an),
    .in_valid(in_valid && cur == 0), .in_ready(ir_a),
    .data_in(din), .nr_sel(nr_sel), .select(select),
    .flush(flush && cur == 0), .key_idx(kidx_a), .round_key(rk_a),
    .out_valid(ov_a), .out_ready(out_ready),
    .data_out(dout_a), .busy(busy_a)
  );

  round_engine #(.SBOX_LAT(3), .LAST_PERM(1)) u_b (
    .clk(clk), .rst_an(rst_an),
    .in_valid(in_valid && cur == 1), .in_ready(ir_b),
    .data_in(din), .nr_sel(nr_sel), .select(select),
    .flush(flush && cur == 1), .key_idx(kidx_b), .round_key(rk_b),
    .out_valid(ov_b), .out_ready(out_ready),
    .data_out(dout_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] y, s, c63;
    c63 = 8'h63;
    for (int x = 0; x < 256; x++) begin
      y = 8'h00;
      for (int c = 1; c < 256; c++)
        if (pmul(8'(x), 8'(c)) == 8'h01) y = 8'(c);
      for (int i = 0; i < 8; i++)
        s[i] = y[i] ^ y[(i + 4) % 8] ^ y[(i + 5) % 8]
             ^ y[(i + 6) % 8] ^ y[(i + 7) % 8] ^ c63[i];
      fwd[x] = s;
      inv[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] d,
                                         input int nrl, input logic sl,
                                         input logic lp);
    logic [127:0] s, p;
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    s = d ^ ktab[0];
    for (int r = 1; r <= nrl; r++) begin
      for (int k = 0; k < 16; k++)
        b[k] = sl ? inv[s[127-8*k -: 8]] : fwd[s[127-8*k -: 8]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = b[4*((c + (row + r) % 4) % 4) + row];
      for (int k = 0; k < 16; k++) s[127-8*k -: 8] = t[k];
      if (r < nrl || lp) begin
        for (int i = 0; i < 128; i++) p[i] = s[(i * 37) % 128];
        s = p;
      end
      s = s ^ ktab[r];
    end
    return s;
  endfunction

  // called at a falling edge with the selected engine idle
  task automatic run_block(input logic [127:0] d, input logic [3:0] ns,
                           input logic sl, input int hold,
                           input int flush_at);
    int L, nrl, lat, k;
    logic [127:0] exp, held;
    L   = (cur == 1) ? 3 : 1;
    nrl = (ns == 0 || ns > 10) ? 10 : int'(ns);
    lat = nrl * (L + 1);
    exp = model(d, nrl, sl, cur == 1);
    chk("idle_ready", {126'd0, ir, busy}, 128'b10);
    chk("idle_kidx", 128'(kidx), 128'd0);
    in_valid  = 1'b1;
    din       = d;
    nr_sel    = ns;
    select    = sl;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    // garbage while busy must be ignored
    din    = {$urandom, $urandom, $urandom, $urandom};
    nr_sel = 4'($urandom);
    select = 1'($urandom);
    k = 0;
    @(negedge clk);
    while (ov !== 1'b1 && k < lat + 4) begin
      chk("round_kidx", 128'(kidx), 128'(k / (L + 1) + 1));
      chk("busy_state", {126'd0, ir, busy}, 128'b01);
      if (k == flush_at) begin
        in_valid = 1'b0;
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_state", {125'd0, ir, busy, ov}, 128'b100);
        chk("flush_data", dout, 128'd0);
        return;
      end
      @(negedge clk);
      k++;
    end
    in_valid = 1'b0;
    chk("latency", 128'(k), 128'(lat));
    chk("done_kidx", 128'(kidx), 128'(nrl));
    chk("result", dout, exp);
    held = dout;
    for (int h = 0; h < hold; h++) begin
      chk("bp_state", {125'd0, ir, busy, ov}, 128'b011);
      chk("bp_data", dout, held);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("drain_state", {125'd0, ir, busy, ov}, 128'b100);
    chk("drain_data", dout, exp);
  endtask

  initial begin
    build_tables();
    for (int i = 0; i < 16; i++) ktab[i] = {4{32'(i)}};
    #12;
    chk("rst_outs", {125'd0, ir, busy, ov}, 128'b100);
    chk("rst_kidx", 128'(kidx), 128'd0);
    chk("rst_data", dout, 128'd0);
    rst_an = 1'b1;
    @(negedge clk);

    run_block(128'h00112233445566778899aabbccddeeff, 4'd3, 1'b0, 0, -1);
    run_block({$urandom, $urandom, $urandom, $urandom}, 4'd0, 1'b0, 0, -1);
    run_block({$urandom, $urandom, $urandom, $urandom}, 4'd15, 1'b1, 0, -1);
    run_block({$urandom, $urandom, $urandom, $urandom}, 4'd4, 1'b1, 5, -1);
    run_block({$urandom, $urandom, $urandom, $urandom}, 4'd2, 1'b0, 0, -1);
    run_block({$urandom, $urandom, $urandom, $urandom}, 4'd5, 1'b0, 0, 3);
    run_block({$urandom, $urandom, $urandom, $urandom}, 4'd6, 1'b1, 0, -1);

    for (int i = 0; i < 16; i++)
      ktab[i] = {$urandom, $urandom, $urandom, $urandom};
    for (int n = 0; n < 8; n++)
      run_block({$urandom, $urandom, $urandom, $urandom},
                4'($urandom), 1'($urandom), int'($urandom_range(0, 2)), -1);

    in_valid = 1'b1;
    din = {$urandom, $urandom, $urandom, $urandom};
    nr_sel = 4'd3;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", {127'd0, busy}, 128'd1);
    rst_an = 1'b0;
    #2;
    chk("arst_outs", {125'd0, ir, busy, ov}, 128'b100);
    chk("arst_kidx", 128'(kidx), 128'd0);
    chk("arst_data", dout, 128'd0);
    #1 rst_an = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst", {125'd0, ir, busy, ov}, 128'b100);
    end

    cur = 1;
    run_block({$urandom, $urandom, $urandom, $urandom}, 4'd2, 1'b0, 0, -1);
    run_block({$urandom, $urandom, $urandom, $urandom}, 4'd2, 1'b1, 1, -1);
    for (int n = 0; n < 3; n++)
      run_block({$urandom, $urandom, $urandom, $urandom},
                4'($urandom), 1'($urandom), 0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
